// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared constants for the iterative square-root engine
package sqrt_pkg;

  localparam int SQRT_WIDTH = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring digit-by-digit trial subtract
module sqrt_step #(
  parameter int HW = 8
) (
  input  logic [HW+1:0] rem_i,
  input  logic [1:0]    bits_i,
  input  logic [HW-1:0] q_i,
  output logic [HW+1:0] rem_o,
  output logic          bit_o
);

  localparam int RW = HW + 2;

  logic [HW+3:0] cand;
  logic [HW+3:0] sub;

  // Two spare top bits keep the comparison free of wraparound.
  assign cand  = {rem_i, bits_i};
  assign sub   = {2'b00, q_i, 2'b01};
  assign bit_o = (cand >= sub);
  assign rem_o = bit_o ? RW'(cand - sub) : RW'(cand);

endmodule

// File: rtl/sqrt_asm.sv
// rtl/sqrt_asm.sv - iterative integer square root, one root bit per clock
module sqrt_asm
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [WIDTH-1:0]   A,
  output logic [WIDTH/2-1:0] result,
  output logic [WIDTH/2:0]   remainder,
  output logic               busy,
  output logic               done
);

  localparam int HW    = WIDTH / 2;
  localparam int CNT_W = $clog2(HW) + 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [HW+1:0]    rem_q, rem_d;
  logic [HW-1:0]    q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [HW+1:0]    step_rem;
  logic             step_bit;

  sqrt_step #(.HW(HW)) u_step (
    .rem_i  (rem_q),
    .bits_i (rad_q[WIDTH-1:WIDTH-2]),
    .q_i    (q_q),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (init) begin
          rad_d   = A;
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(HW);
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        q_d   = {q_q[HW-2:0], step_bit};
        rad_d = {rad_q[WIDTH-3:0], 2'b00};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Final remainder is at most 2*root, so the top bit of rem_q is always zero here.
  assign result    = q_q;
  assign remainder = rem_q[HW:0];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sqrt_asm.sv
// tb/tb_sqrt_asm.sv - directed and swept checks of the square-root engine
module tb_sqrt_asm;

  logic        clk;
  logic        reset;
  logic        init;
  logic [15:0] A;
  logic [7:0]  result;
  logic [8:0]  remainder;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit overlap_seen = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  r;
    logic [8:0]  rm;
  } vec_t;

  vec_t vecs[12];

  sqrt_asm #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .A         (A),
    .result    (result),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_seen = 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_init(input logic [15:0] a);
    @(negedge clk);
    A    = a;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Waits up to 20 cycles for done; lat counts cycles after the accepting edge.
  task automatic wait_done(input int start, output int lat);
    int n;
    n = start;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  function automatic int ref_root(input int a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  initial begin
    int lat;
    int r;
    int done_cnt;
    int run;
    int max_run;

    vecs[0]  = '{16'h0441, 8'h21, 9'd0};
    vecs[1]  = '{16'hFFFF, 8'hFF, 9'd510};
    vecs[2]  = '{16'd0,    8'd0,  9'd0};
    vecs[3]  = '{16'd2,    8'd1,  9'd1};
    vecs[4]  = '{16'd1000, 8'd31, 9'd39};
    vecs[5]  = '{16'd1,    8'd1,  9'd0};
    vecs[6]  = '{16'd3,    8'd1,  9'd2};
    vecs[7]  = '{16'd4,    8'd2,  9'd0};
    vecs[8]  = '{16'd65025, 8'd255, 9'd0};
    vecs[9]  = '{16'd65024, 8'd254, 9'd508};
    vecs[10] = '{16'd15,   8'd3,  9'd6};
    vecs[11] = '{16'd255,  8'd15, 9'd30};

    reset = 1'b0;
    init  = 1'b0;
    A     = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_remainder", remainder, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      pulse_init(vecs[i].a);
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_done(0, lat);
      check($sformatf("v%0d_latency", i), lat, 8);
      check($sformatf("v%0d_result", i), result, vecs[i].r);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].rm);
      @(negedge clk);
      check($sformatf("v%0d_done_held", i), done, 1);
    end

    // Back-to-back: restart in the first DONE cycle.
    pulse_init(16'd2);
    wait_done(0, lat);
    check("b2b_first_result", result, 1);
    check("b2b_first_rem", remainder, 1);
    A    = 16'd1000;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("b2b_done_dropped", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(0, lat);
    check("b2b_latency", lat, 8);
    check("b2b_result", result, 31);
    check("b2b_rem", remainder, 39);

    // init during CALC is ignored.
    pulse_init(16'h0441);
    repeat (2) @(negedge clk);
    A    = 16'd1000;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_done(3, lat);
    check("ign_latency", lat, 8);
    check("ign_result", result, 8'h21);
    check("ign_rem", remainder, 0);

    // Asynchronous reset mid-calculation.
    pulse_init(16'h0441);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_rem", remainder, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    pulse_init(16'h0441);
    wait_done(0, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_result", result, 8'h21);
    check("post_rst_rem", remainder, 0);

    // init held high: one-cycle done per result, restart on each DONE entry.
    @(negedge clk);
    A        = 16'd1000;
    init     = 1'b1;
    done_cnt = 0;
    run      = 0;
    max_run  = 0;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (result !== 8'd31 || remainder !== 9'd39) begin
          check("hold_value", {result, remainder}, {8'd31, 9'd39});
        end
      end else begin
        run = 0;
      end
    end
    init = 1'b0;
    check("hold_done_count", done_cnt, 3);
    check("hold_done_width", max_run, 1);
    @(negedge clk);

    // Random sweep against a search-based reference.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 65535));
      pulse_init(a);
      wait_done(0, lat);
      r = ref_root(a);
      check("sweep_result", result, r);
      check("sweep_rem", remainder, a - r * r);
    end

    check("busy_done_overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
